pwm_capture: RTL and testbench

- Receive-side companion to the team's PWM generator: samples a PWM waveform and measures its period and high time in clk_100m cycles.
- Converts each complete period to an 8-bit duty code equivalent to the generator's 8-bit data word, so a loopback bench can compare them directly.
- Sits between a pad/loopback PWM line and downstream logic that needs the recovered sample and waveform period.

---
 rtl/pwm_capture_if.sv | 25 ++
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_pwm_capture.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// PWM capture port bundle: sampled line in, recovered duty/period out.
// The master drives the line; the capture block is the slave.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_i;
  logic [7:0]       duty_o;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;
  logic             ovr_o;

  modport master (
    output pwm_i,
    input  duty_o, period_o, high_o,
    input  valid_o, timeout_o, ovr_o
  );

  modport slave (
    input  pwm_i,
    output duty_o, period_o, high_o,
    output valid_o, timeout_o, ovr_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_i between rises
// and converts them to an 8-bit duty code by restoring division.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk_100m,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);

  state_e state_q, state_d;
  logic sy1_q, sy2_q, sd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       quo_q, quo_d;
  logic [2:0]       step_q, step_d;
  logic             armed_q, armed_d;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic             ovr_q, ovr_d;

  logic             rise;
  logic             to_hit;
  logic [CNT_W:0]   r;
  logic             qbit;
  logic [7:0]       quo_n;

  assign rise   = sy2_q & ~sd_q;
  assign to_hit = ~rise & (state_q == IDLE) & (cnt_q >= TO);
  // rem < per_l always, so the shifted remainder fits in CNT_W+1 bits
  assign r      = {rem_q, 1'b0};
  assign qbit   = r >= {1'b0, per_q};
  assign quo_n  = {quo_q[6:0], qbit};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    per_d    = per_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    armed_d  = armed_q;
    duty_d   = duty_q;
    period_d = period_q;
    high_d   = high_q;
    tout_d   = tout_q;
    valid_d  = 1'b0;
    ovr_d    = 1'b0;

    if (rise) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
      if (sy2_q && hcnt_q != CMAX) hcnt_d = hcnt_q + 1'b1;
    end

    if (rise) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (state_q == IDLE) begin
        per_d   = cnt_q;
        hi_d    = hcnt_q;
        rem_d   = hcnt_q;
        quo_d   = '0;
        step_d  = '0;
        state_d = DIV;
      end else begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (to_hit) begin
          duty_d   = sy2_q ? 8'hff : 8'h00;
          period_d = '0;
          high_d   = sy2_q ? TO : '0;
          valid_d  = 1'b1;
          tout_d   = 1'b1;
          armed_d  = 1'b0;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DIV: begin
        rem_d  = qbit ? CNT_W'(r - {1'b0, per_q}) : r[CNT_W-1:0];
        quo_d  = quo_n;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          duty_d   = quo_n;
          period_d = per_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          tout_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sy1_q    <= 1'b0;
      sy2_q    <= 1'b0;
      sd_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      armed_q  <= 1'b0;
      duty_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sy1_q    <= bus.pwm_i;
      sy2_q    <= sy1_q;
      sd_q     <= sy2_q;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      armed_q  <= armed_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.duty_o    = duty_q;
  assign bus.period_o  = period_q;
  assign bus.high_o    = high_q;
  assign bus.valid_o   = valid_q;
  assign bus.timeout_o = tout_q;
  assign bus.ovr_o     = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM streams against a
// model that works from driven edges, high-sample counts and cycle times.
module tb_pwm_capture;
  localparam int CW  = 16;
  localparam int TO  = 2000;
  localparam int LAT = 11;
  localparam int OVL = 3;

  logic clk_100m = 1'b0;
  logic rst_n    = 1'b0;

  pwm_capture_if #(.CNT_W(CW)) bus ();

  pwm_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  int cyc = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  typedef struct {
    int due;
    int duty;
    int per;
    int hi;
    int to;
  } exp_t;

  exp_t eq[$];
  int   oq[$];
  int   nerr = 0;
  int   nchk = 0;

  logic line = 1'b0;
  bit   armed_m = 1'b0;
  int   prev_c = 0;
  int   highs = 0;
  int   last_acc = -1000;
  int   to_due = 1 << 30;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    bit   hv;
    bit   ho;
    exp_t e;
    @(negedge clk_100m);
    if (cyc == to_due) begin
      eq.push_back('{cyc, line ? 255 : 0, 0, line ? TO : 0, 1});
      armed_m = 1'b0;
      to_due  = cyc + TO + 1;
    end
    hv = eq.size() > 0 && eq[0].due <= cyc;
    if (bus.valid_o === 1'b1 || hv) begin
      chk("valid", bus.valid_o, 32'(hv));
      if (hv) begin
        e = eq.pop_front();
        if (bus.valid_o === 1'b1) begin
          chk("duty", bus.duty_o, e.duty);
          chk("period", bus.period_o, e.per);
          chk("high", bus.high_o, e.hi);
          chk("timeout", bus.timeout_o, e.to);
        end
      end
    end
    ho = oq.size() > 0 && oq[0] <= cyc;
    if (bus.ovr_o === 1'b1 || ho) begin
      chk("ovr", bus.ovr_o, 32'(ho));
      if (ho) void'(oq.pop_front());
    end
    if (v && !line) begin
      if (!armed_m) begin
        armed_m = 1'b1;
      end else if (cyc - last_acc < 10) begin
        oq.push_back(cyc + OVL);
      end else begin
        eq.push_back('{cyc + LAT, (highs * 256) / (cyc - prev_c),
                       cyc - prev_c, highs, 0});
        last_acc = cyc;
      end
      prev_c = cyc;
      highs  = 0;
      to_due = cyc + TO + 3;
    end
    if (v) highs++;
    line      = v;
    bus.pwm_i = v;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic per(input int p, input int h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic do_reset();
    @(negedge clk_100m);
    rst_n     = 1'b0;
    bus.pwm_i = 1'b0;
    #1;
    chk("rst_duty", bus.duty_o, 0);
    chk("rst_period", bus.period_o, 0);
    chk("rst_high", bus.high_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_ovr", bus.ovr_o, 0);
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    eq.delete();
    oq.delete();
    line     = 1'b0;
    armed_m  = 1'b0;
    highs    = 0;
    prev_c   = cyc;
    last_acc = -1000;
    to_due   = cyc + TO + 1;
  endtask

  initial begin
    int p;
    bus.pwm_i = 1'b0;
    do_reset();
    hold(1'b0, TO + 50);
    repeat (6) per(256, 64);
    per(100, 50);
    per(256, 255);
    per(256, 1);
    repeat (25) begin
      p = int'($urandom_range(600, 10));
      per(p, int'($urandom_range(p - 1, 1)));
    end
    repeat (12) per(8, 4);
    repeat (30) begin
      p = int'($urandom_range(16, 6));
      per(p, int'($urandom_range(p - 1, 1)));
    end
    per(256, 64);
    hold(1'b1, TO + 500);
    hold(1'b0, 128);
    repeat (4) per(256, 128);
    per(256, 192);
    hold(1'b1, 6);
    do_reset();
    hold(1'b0, 40);
    repeat (5) per(256, 192);
    step(1'b1);
    hold(1'b0, 30);
    chk("drain", 32'(eq.size() + oq.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
